// File: rtl/md_unit_mc_pkg.sv
// Shared types and helpers for the multi-cycle multiply/divide unit.
package md_pkg;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } md_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_t;

  // Operations that occupy the unit for several cycles.
  function automatic logic is_md_long(input md_op_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_div(input md_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/md_unit_mc_if.sv
// Issue/result bundle between the execute stage and the MD unit.
// Handshake: the master raises start for one cycle with op/a/b valid; the
// unit accepts only while busy is low (there is no separate ready, busy low
// is the ready). A long op holds busy high until the commit edge, after which
// done pulses for exactly one cycle with the new hi/lo. cancel drops any
// in-flight op and also wins over a start in the same cycle.
interface md_unit_mc_if #(
  parameter int WIDTH = 32
);
  import md_pkg::*;

  logic             start;
  md_op_t           op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  md_state_t        dbg_state;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo, dbg_state
  );

endinterface

// File: rtl/md_unit_mc_div_core.sv
// Iterative restoring divider on magnitudes, one quotient bit per cycle.
// The first step happens on the load edge using the raw operands, so the
// result is settled WIDTH edges after load begins.
module md_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int IW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [IW-1:0]    iter_q;

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract if it fits, and shift the quotient bit in.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] dvs
  );
    logic [WIDTH:0] part;
    logic [WIDTH:0] trial;
    part  = {rem, quo[WIDTH-1]};
    trial = part - {1'b0, dvs};
    if (trial[WIDTH]) begin
      return {part[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    end
    return {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
  endfunction

  // Load starts a fresh division; otherwise step until the bit count runs out.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      iter_q <= '0;
    end else if (load) begin
      {rem_q, quo_q} <= div_step('0, dividend, divisor);
      dvs_q          <= divisor;
      iter_q         <= IW'(WIDTH - 1);
    end else if (iter_q != '0) begin
      {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
      iter_q         <= iter_q - 1'b1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/md_unit_mc.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
module md_unit_mc
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic         clk,
  input logic         reset,
  md_unit_mc_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  md_state_t        state;
  md_state_t        state_nxt;
  logic [CW-1:0]    cnt;
  md_op_t           op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             issue;
  logic             issue_long;
  logic             commit;
  logic [2*WIDTH-1:0] prod;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  // A start is only honoured when idle; cancel suppresses it entirely.
  assign issue      = (state == IDLE) && md.start && !md.cancel;
  assign issue_long = issue && is_md_long(md.op);
  assign commit     = (state == RUN) && !md.cancel && (cnt == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: leave RUN on cancel or after the last counted cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue_long) state_nxt = RUN;
      RUN:     if (md.cancel || (cnt == '0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    md.busy      = (state == RUN);
    md.dbg_state = state;
  end

  // Operand latch and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= NOP;
      a_q  <= '0;
      b_q  <= '0;
      cnt  <= '0;
    end else if (issue_long) begin
      op_q <= md.op;
      a_q  <= md.a;
      b_q  <= md.b;
      cnt  <= is_div(md.op) ? DIV_LOAD : MULT_LOAD;
    end else if (state == RUN) begin
      if (md.cancel)       cnt <= '0;
      else if (cnt != '0)  cnt <= cnt - 1'b1;
    end
  end

  // Full-width product; sign-extending first makes the low 2*WIDTH bits the signed product.
  always_comb begin
    if (op_q == MULT) prod = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    else              prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  end

  assign a_neg = (op_q == DIV) && a_q[WIDTH-1];
  assign b_neg = (op_q == DIV) && b_q[WIDTH-1];

  // Magnitude division: iterative when the latency covers one bit per cycle,
  // otherwise a combinational divide on the latched operands.
  if (DIV_CYCLES >= WIDTH) begin : g_iter
    logic             in_signed;
    logic [WIDTH-1:0] in_a_mag;
    logic [WIDTH-1:0] in_b_mag;
    assign in_signed = (md.op == DIV);
    assign in_a_mag  = (in_signed && md.a[WIDTH-1]) ? -md.a : md.a;
    assign in_b_mag  = (in_signed && md.b[WIDTH-1]) ? -md.b : md.b;
    md_div_core #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .reset     (reset),
      .load      (issue_long && is_div(md.op)),
      .dividend  (in_a_mag),
      .divisor   (in_b_mag),
      .quotient  (q_mag),
      .remainder (r_mag)
    );
  end else begin : g_comb
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    assign a_mag = a_neg ? -a_q : a_q;
    assign b_mag = b_neg ? -b_q : b_q;
    // Guarded divide so a zero divisor never produces X.
    always_comb begin
      q_mag = '1;
      r_mag = a_mag;
      if (b_mag != '0) begin
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
      end
    end
  end

  // Sign fix-up and result select; zero divisor gives lo=all-ones, hi=dividend.
  always_comb begin
    quo = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem = a_neg ? -r_mag : r_mag;
    if (is_div(op_q)) begin
      if (b_q == '0) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // HI/LO: long-op commit, or direct MTHI/MTLO write on an idle issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (issue && (md.op == MTHI)) begin
        hi_q <= md.a;
      end else if (issue && (md.op == MTLO)) begin
        lo_q <= md.a;
      end
    end
  end

  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit_mc.sv
// Bench for md_unit_mc: default instance (combinational divide path) and a
// second instance with DIV_CYCLES=WIDTH (iterative divider) and MULT_CYCLES=1.
module tb_md_unit_mc;
  import md_pkg::*;

  localparam int W      = 32;
  localparam int A_MULT = 5;
  localparam int A_DIV  = 10;
  localparam int B_MULT = 1;
  localparam int B_DIV  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_mc_if #(.WIDTH(W)) if_a ();
  md_unit_mc_if #(.WIDTH(W)) if_b ();

  md_unit_mc #(.WIDTH(W), .MULT_CYCLES(A_MULT), .DIV_CYCLES(A_DIV)) dut_a (
    .clk(clk), .reset(reset), .md(if_a.slave)
  );
  md_unit_mc #(.WIDTH(W), .MULT_CYCLES(B_MULT), .DIV_CYCLES(B_DIV)) dut_b (
    .clk(clk), .reset(reset), .md(if_b.slave)
  );

  logic         sel;
  logic         start_v;
  logic         cancel_v;
  md_op_t       op_v;
  logic [W-1:0] a_v;
  logic [W-1:0] b_v;

  assign if_a.start  = start_v & ~sel;
  assign if_b.start  = start_v & sel;
  assign if_a.cancel = cancel_v & ~sel;
  assign if_b.cancel = cancel_v & sel;
  assign if_a.op     = op_v;
  assign if_b.op     = op_v;
  assign if_a.a      = a_v;
  assign if_b.a      = a_v;
  assign if_a.b      = b_v;
  assign if_b.b      = b_v;

  logic         s_busy;
  logic         s_done;
  logic [W-1:0] s_hi;
  logic [W-1:0] s_lo;
  assign s_busy = sel ? if_b.busy : if_a.busy;
  assign s_done = sel ? if_b.done : if_a.done;
  assign s_hi   = sel ? if_b.hi   : if_a.hi;
  assign s_lo   = sel ? if_b.lo   : if_a.lo;

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   model_hi[2];
  logic [W-1:0]   model_lo[2];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model returning {hi, lo}.
  function automatic logic [2*W-1:0] model(input md_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] q;
    logic signed [63:0] r;
    logic [2*W-1:0]     p;
    sa = $signed(a);
    sb = $signed(b);
    p  = '0;
    case (op)
      MULT:  p = sa * sb;
      MULTU: p = {32'b0, a} * {32'b0, b};
      DIV: begin
        if (b == '0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      DIVU: begin
        if (b == '0) p = {a, 32'hFFFF_FFFF};
        else         p = {a % b, a / b};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_op(input string name, input md_op_t op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp);
    int n;
    int busy_cnt;
    bit seen;
    logic [2*W-1:0] got;
    n = (op == DIV || op == DIVU) ? (sel ? B_DIV : A_DIV) : (sel ? B_MULT : A_MULT);
    @(negedge clk);
    op_v = op; a_v = a; b_v = b; start_v = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    start_v = 1'b0; op_v = NOP;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (s_done) seen = 1'b1;
      else begin
        if (s_busy) busy_cnt++;
        @(negedge clk);
      end
    end
    check({name, " done_seen"}, W'(seen), W'(1));
    check({name, " busy_cycles"}, W'(busy_cnt), W'(n));
    check({name, " busy_at_done"}, W'(s_busy), W'(0));
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check({name, " hi"}, s_hi, got[2*W-1:W]);
      check({name, " lo"}, s_lo, got[W-1:0]);
      model_hi[sel] = got[2*W-1:W];
      model_lo[sel] = got[W-1:0];
    end
    @(negedge clk);
    check({name, " done_pulse"}, W'(s_done), W'(0));
  endtask

  // Issue a MULT on instance A and cancel it during busy cycle k.
  task automatic cancel_at(input string name, input int k);
    bit seen;
    sel = 1'b0;
    @(negedge clk);
    op_v = MULT; a_v = 32'd3; b_v = 32'd4; start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0; op_v = NOP;
    repeat (k - 1) @(negedge clk);
    check({name, " busy_before"}, W'(s_busy), W'(1));
    cancel_v = 1'b1;
    @(negedge clk);
    cancel_v = 1'b0;
    check({name, " busy_after"}, W'(s_busy), W'(0));
    check({name, " no_done"}, W'(s_done), W'(0));
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (s_done) seen = 1'b1;
    end
    check({name, " late_done"}, W'(seen), W'(0));
    check({name, " hi_kept"}, s_hi, model_hi[0]);
    check({name, " lo_kept"}, s_lo, model_lo[0]);
  endtask

  typedef struct {
    md_op_t       op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    md_op_t rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[2] = '{DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[4] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[6] = '{DIVU,  32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[7] = '{DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[8] = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9] = '{DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};

    reset = 1'b1; sel = 1'b0; start_v = 1'b0; cancel_v = 1'b0;
    op_v = NOP; a_v = '0; b_v = '0;
    model_hi[0] = '0; model_lo[0] = '0; model_hi[1] = '0; model_lo[1] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset a_hi",    if_a.hi, '0);
    check("reset a_lo",    if_a.lo, '0);
    check("reset a_busy",  W'(if_a.busy), W'(0));
    check("reset a_done",  W'(if_a.done), W'(0));
    check("reset a_state", W'(if_a.dbg_state), W'(IDLE));
    check("reset b_hi",    if_b.hi, '0);
    check("reset b_busy",  W'(if_b.busy), W'(0));
    check("reset b_state", W'(if_b.dbg_state), W'(IDLE));

    // Table vectors through both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 10; i++) begin
        run_op($sformatf("vec%0d_dut%0d", i, s), vecs[i].op, vecs[i].a, vecs[i].b,
               {vecs[i].hi, vecs[i].lo});
      end
    end

    // Random operations against the reference model.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 16; i++) begin
        rop = md_op_t'($urandom_range(1, 4));
        ra  = $urandom();
        case ($urandom_range(0, 3))
          0:       rb = '0;
          1:       rb = W'($urandom_range(1, 20));
          2:       rb = -W'($urandom_range(1, 20));
          default: rb = $urandom();
        endcase
        run_op($sformatf("rnd%0d_dut%0d", i, s), rop, ra, rb, model(rop, ra, rb));
      end
    end

    // MTHI then MTLO: immediate write, never busy.
    sel = 1'b0;
    @(negedge clk);
    op_v = MTHI; a_v = 32'h1234; start_v = 1'b1;
    @(negedge clk);
    op_v = MTLO; a_v = 32'h5678;
    check("mthi hi",   s_hi, 32'h1234);
    check("mthi busy", W'(s_busy), W'(0));
    @(negedge clk);
    start_v = 1'b0; op_v = NOP;
    check("mtlo lo",   s_lo, 32'h5678);
    check("mtlo hi",   s_hi, 32'h1234);
    check("mtlo busy", W'(s_busy), W'(0));
    check("mtlo done", W'(s_done), W'(0));
    model_hi[0] = 32'h1234;
    model_lo[0] = 32'h5678;

    // Cancel mid-operation and on the final busy cycle.
    cancel_at("cancel_c3", 3);
    cancel_at("cancel_last", A_MULT);

    // start+cancel together: MTLO suppressed, MULT not issued.
    @(negedge clk);
    op_v = MTLO; a_v = 32'hDEAD; start_v = 1'b1; cancel_v = 1'b1;
    @(negedge clk);
    op_v = MULT; a_v = 32'd9; b_v = 32'd9;
    check("startcancel mtlo lo", s_lo, model_lo[0]);
    @(negedge clk);
    start_v = 1'b0; cancel_v = 1'b0; op_v = NOP;
    check("startcancel mult busy", W'(s_busy), W'(0));
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (s_done || s_busy) seen = 1'b1;
    end
    check("startcancel no_activity", W'(seen), W'(0));
    check("startcancel hi", s_hi, model_hi[0]);

    // start while busy is ignored.
    @(negedge clk);
    op_v = MULT; a_v = 32'd6; b_v = 32'd7; start_v = 1'b1;
    exp_q.push_back(model(MULT, 32'd6, 32'd7));
    @(negedge clk);
    op_v = MTHI; a_v = 32'hBAD;
    @(negedge clk);
    start_v = 1'b0; op_v = NOP;
    check("busy_start hi_untouched", s_hi, model_hi[0]);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (s_done) seen = 1'b1;
      else @(negedge clk);
    end
    check("busy_start done_seen", W'(seen), W'(1));
    if (exp_q.size() > 0) begin
      logic [2*W-1:0] got;
      got = exp_q.pop_front();
      check("busy_start hi", s_hi, got[2*W-1:W]);
      check("busy_start lo", s_lo, got[W-1:0]);
      model_hi[0] = got[2*W-1:W];
      model_lo[0] = got[W-1:0];
    end

    // Reset in the middle of a DIV.
    @(negedge clk);
    op_v = DIV; a_v = 32'd100; b_v = 32'd7; start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0; op_v = NOP;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset hi",    s_hi, '0);
    check("midreset lo",    s_lo, '0);
    check("midreset busy",  W'(s_busy), W'(0));
    check("midreset done",  W'(s_done), W'(0));
    check("midreset state", W'(if_a.dbg_state), W'(IDLE));
    model_hi[0] = '0; model_lo[0] = '0; model_hi[1] = '0; model_lo[1] = '0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (s_done) seen = 1'b1;
    end
    check("midreset no_done", W'(seen), W'(0));
    run_op("post_reset", DIVU, 32'd100, 32'd7, model(DIVU, 32'd100, 32'd7));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
